// File: rtl/pid_pkg.sv
// Shared widths, default gains and the signed saturation helper for the heading PID stage.
package pid_pkg;

    localparam int unsigned ERR_W    = 12;
    localparam int unsigned ESAT_W   = 10;
    localparam int unsigned FRWRD_W  = 10;
    localparam int unsigned SPD_W    = 11;
    localparam int unsigned P_W      = 14;
    localparam int unsigned D_W      = 13;
    localparam int unsigned DDIFF_W  = 7;
    localparam int unsigned I_W      = 12;
    localparam int unsigned INTEG_W  = 16;
    localparam int unsigned PID_W    = 14;
    localparam int unsigned SUM_W    = FRWRD_W + 2;
    localparam int unsigned ADJ_SHIFT = 3;

    localparam int unsigned P_COEFF_DEF = 8;
    localparam int unsigned D_COEFF_DEF = 6;
    localparam int unsigned I_SHIFT_DEF = 4;

    // Clamp a signed value to the range representable in 'width' bits.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                      input int unsigned width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 32'd1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/pid_ctrl_sat.sv
// Parameterized combinational signed saturator (IN_W bits down to OUT_W bits).
module pid_sat
    import pid_pkg::*;
#(
    parameter int unsigned IN_W  = 12,
    parameter int unsigned OUT_W = 10
) (
    input  logic signed [IN_W-1:0]  val_i,
    output logic signed [OUT_W-1:0] sat_o
);

    always_comb begin
        sat_o = OUT_W'(sat_signed(32'(val_i), OUT_W));
    end

endmodule

// File: rtl/pid_ctrl.sv
// Heading PID stage: turns heading error and forward speed into left/right wheel speeds,
// two clocks after each err_vld.
module pid_ctrl
    import pid_pkg::*;
#(
    parameter int unsigned P_COEFF = P_COEFF_DEF,
    parameter int unsigned D_COEFF = D_COEFF_DEF,
    parameter int unsigned I_SHIFT = I_SHIFT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      moving,
    input  logic                      err_vld,
    input  logic signed [ERR_W-1:0]   error,
    input  logic        [FRWRD_W-1:0] frwrd,
    output logic signed [SPD_W-1:0]   lft_spd,
    output logic signed [SPD_W-1:0]   rght_spd,
    output logic                      spd_vld
);

    logic signed [ESAT_W-1:0]  err_sat;
    logic signed [ESAT_W:0]    d_diff_full;
    logic signed [DDIFF_W-1:0] d_diff;
    logic signed [P_W-1:0]     p_term;
    logic signed [D_W-1:0]     d_term;
    logic signed [I_W-1:0]     i_term;

    logic signed [INTEG_W-1:0] integ_q, integ_d, integ_ext, integ_sum;
    logic signed [ESAT_W-1:0]  prev_err_q, prev_err_d;
    logic                      integ_ovf;

    logic signed [P_W-1:0]     p_q;
    logic signed [I_W-1:0]     i_q;
    logic signed [D_W-1:0]     d_q;
    logic        [FRWRD_W-1:0] frwrd_q;
    logic                      vld1_q;

    logic signed [PID_W-1:0]   pid;
    logic signed [SUM_W-1:0]   lft_sum, rght_sum;
    logic signed [SPD_W-1:0]   lft_sat, rght_sat;
    logic signed [SPD_W-1:0]   lft_spd_q, rght_spd_q;
    logic                      spd_vld_q;

    pid_sat #(.IN_W(ERR_W), .OUT_W(ESAT_W)) u_sat_err (
        .val_i (error),
        .sat_o (err_sat)
    );

    assign d_diff_full = (ESAT_W+1)'(err_sat) - (ESAT_W+1)'(prev_err_q);

    pid_sat #(.IN_W(ESAT_W+1), .OUT_W(DDIFF_W)) u_sat_ddiff (
        .val_i (d_diff_full),
        .sat_o (d_diff)
    );

    assign p_term = P_W'(err_sat) * $signed(P_W'(P_COEFF));
    assign d_term = D_W'(d_diff) * $signed(D_W'(D_COEFF));

    // Integrator holds instead of wrapping when the add would overflow.
    assign integ_ext = INTEG_W'(err_sat);
    assign integ_sum = integ_q + integ_ext;
    assign integ_ovf = (integ_q[INTEG_W-1] == integ_ext[INTEG_W-1]) &&
                       (integ_sum[INTEG_W-1] != integ_q[INTEG_W-1]);

    always_comb begin
        integ_d    = integ_q;
        prev_err_d = prev_err_q;
        if (!moving) begin
            integ_d    = '0;
            prev_err_d = '0;
        end else if (err_vld) begin
            prev_err_d = err_sat;
            if (!integ_ovf) integ_d = integ_sum;
        end
    end

    // I term reflects the sample being accepted this cycle.
    assign i_term = I_W'(integ_d >>> I_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ_q    <= '0;
            prev_err_q <= '0;
            p_q        <= '0;
            i_q        <= '0;
            d_q        <= '0;
            frwrd_q    <= '0;
            vld1_q     <= 1'b0;
        end else begin
            integ_q    <= integ_d;
            prev_err_q <= prev_err_d;
            vld1_q     <= err_vld;
            if (err_vld) begin
                p_q     <= p_term;
                i_q     <= i_term;
                d_q     <= d_term;
                frwrd_q <= frwrd;
            end
        end
    end

    assign pid      = PID_W'(p_q) + PID_W'(i_q) + PID_W'(d_q);
    assign lft_sum  = $signed({2'b00, frwrd_q}) + SUM_W'(pid >>> ADJ_SHIFT);
    assign rght_sum = $signed({2'b00, frwrd_q}) - SUM_W'(pid >>> ADJ_SHIFT);

    pid_sat #(.IN_W(SUM_W), .OUT_W(SPD_W)) u_sat_lft (
        .val_i (lft_sum),
        .sat_o (lft_sat)
    );

    pid_sat #(.IN_W(SUM_W), .OUT_W(SPD_W)) u_sat_rght (
        .val_i (rght_sum),
        .sat_o (rght_sat)
    );

    // Outputs update only on a valid stage-1 sample and are forced to zero when not moving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_spd_q  <= '0;
            rght_spd_q <= '0;
            spd_vld_q  <= 1'b0;
        end else begin
            spd_vld_q <= vld1_q;
            if (vld1_q) begin
                lft_spd_q  <= moving ? lft_sat  : '0;
                rght_spd_q <= moving ? rght_sat : '0;
            end
        end
    end

    assign lft_spd  = lft_spd_q;
    assign rght_spd = rght_spd_q;
    assign spd_vld  = spd_vld_q;

endmodule

// File: tb/tb_pid_ctrl.sv
// Directed bench for pid_ctrl with hand-computed wheel speeds.
module tb_pid_ctrl;

    logic               clk     = 1'b0;
    logic               rst_n   = 1'b0;
    logic               moving  = 1'b0;
    logic               err_vld = 1'b0;
    logic signed [11:0] error   = '0;
    logic        [9:0]  frwrd   = '0;
    logic signed [10:0] lft_spd;
    logic signed [10:0] rght_spd;
    logic               spd_vld;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    pid_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .moving   (moving),
        .err_vld  (err_vld),
        .error    (error),
        .frwrd    (frwrd),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .spd_vld  (spd_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        err_vld = 1'b0;
        rst_n   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic pulse(input logic signed [11:0] e, input logic [9:0] f);
        error   = e;
        frwrd   = f;
        err_vld = 1'b1;
        step();
        err_vld = 1'b0;
    endtask

    initial begin
        int  prev_rght;
        int  last_rght;
        int  last_lft;
        bit  mono_ok;
        bit  vld_ok;

        // Reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            error   = 12'($urandom);
            frwrd   = 10'($urandom);
            moving  = 1'($urandom);
            err_vld = 1'($urandom);
            step();
            chk("rst_lft",  32'(lft_spd),  0);
            chk("rst_rght", 32'(rght_spd), 0);
            chk("rst_vld",  32'(spd_vld),  0);
        end
        err_vld = 1'b0;
        error   = '0;
        moving  = 1'b1;
        rst_n   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_vld", 32'(spd_vld), 0);
            chk("post_rst_lft", 32'(lft_spd), 0);
        end

        // Zero error: latency and straight-ahead speed
        pulse(12'sd0, 10'h300);
        chk("lat_n1_vld", 32'(spd_vld), 0);
        step();
        chk("lat_n2_vld", 32'(spd_vld), 1);
        chk("zero_lft",   32'(lft_spd),  768);
        chk("zero_rght",  32'(rght_spd), 768);
        step();
        chk("vld_pulse_end", 32'(spd_vld), 0);
        chk("hold_lft",      32'(lft_spd), 768);

        // Max positive error, left saturates
        do_reset();
        moving = 1'b1;
        pulse(12'h7FF, 10'h300);
        step();
        chk("pos_vld",  32'(spd_vld),  1);
        chk("pos_lft",  32'(lft_spd),  1023);
        chk("pos_rght", 32'(rght_spd), 206);

        // Negative error
        do_reset();
        moving = 1'b1;
        pulse(12'hF00, 10'h100);
        step();
        chk("neg_vld",  32'(spd_vld),  1);
        chk("neg_lft",  32'(lft_spd),  -50);
        chk("neg_rght", 32'(rght_spd), 562);

        // Back-to-back samples
        do_reset();
        moving = 1'b1;
        pulse(12'sd0, 10'h100);
        pulse(12'sd8, 10'h100);
        chk("b2b_vld0",  32'(spd_vld), 1);
        chk("b2b_lft0",  32'(lft_spd), 256);
        step();
        chk("b2b_vld1",  32'(spd_vld),  1);
        chk("b2b_lft1",  32'(lft_spd),  270);
        chk("b2b_rght1", 32'(rght_spd), 242);
        step();
        chk("b2b_end", 32'(spd_vld), 0);

        // Reset mid-pipeline leaves no stale valid
        pulse(12'sd100, 10'h200);
        rst_n = 1'b0;
        #1;
        chk("midrst_vld", 32'(spd_vld), 0);
        chk("midrst_lft", 32'(lft_spd), 0);
        step();
        rst_n = 1'b1;
        vld_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (spd_vld !== 1'b0) vld_ok = 1'b0;
        end
        chk("midrst_no_stale", 32'(vld_ok), 1);

        // Sustained max error: integrator saturates without wrapping
        do_reset();
        moving    = 1'b1;
        mono_ok   = 1'b1;
        vld_ok    = 1'b1;
        prev_rght = 0;
        last_rght = 0;
        last_lft  = 0;
        for (int i = 0; i < 200; i++) begin
            pulse(12'h7FF, 10'h300);
            step();
            if (spd_vld !== 1'b1) vld_ok = 1'b0;
            last_rght = 32'(rght_spd);
            last_lft  = 32'(lft_spd);
            if (i >= 2 && last_rght > prev_rght) mono_ok = 1'b0;
            prev_rght = last_rght;
        end
        chk("integ_vld_each", 32'(vld_ok),  1);
        chk("integ_monotonic", 32'(mono_ok), 1);
        chk("integ_rght_final", last_rght, 2);
        chk("integ_lft_final",  last_lft,  1023);
        chk("integ_hold_value", 32'(dut.integ_q), 32704);

        // Drop moving: outputs zero, integrator cleared
        moving = 1'b0;
        pulse(12'h7FF, 10'h300);
        step();
        chk("stop_vld",   32'(spd_vld),  1);
        chk("stop_lft",   32'(lft_spd),  0);
        chk("stop_rght",  32'(rght_spd), 0);
        chk("stop_integ", 32'(dut.integ_q), 0);

        // Resume: no stale I or D contribution
        moving = 1'b1;
        pulse(12'sd0, 10'h120);
        step();
        chk("resume_vld",  32'(spd_vld),  1);
        chk("resume_lft",  32'(lft_spd),  288);
        chk("resume_rght", 32'(rght_spd), 288);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
